// File: rtl/roic_deser_align_ctrl.sv
// rtl/roic_deser_align_ctrl.sv - ROIC deserializer reset / tap-load / per-channel alignment sequencer
//
// Purpose: on start, resets the deserializers for RST_CYC cycles, loads the
// delay tap, then requests alignment from each channel in turn. Each channel
// either acks (ch_done) or times out after TIMEOUT_CYC cycles (ch_fail).
// Optional feature macro: ROIC_ALIGN_RETRY_EN, which retries a timed-out
// channel once with tap+1 (saturating at 31) before flagging ch_fail.
//
// Ports:
//   clk_100mhz  in   clock
//   rst_n_eim   in   asynchronous active-low reset
//   start       in   one-cycle sweep request (ignored while busy)
//   abort       in   level, ends a sweep in progress
//   tap_init    in   [4:0] tap value latched at start
//   align_ack   in   [NUM_CH-1:0] per-channel alignment-complete strobe
//   deser_reset out  deserializer reset
//   dly_tap_ld  out  tap load strobe
//   dly_tap_in  out  [4:0] tap value being loaded
//   align_req   out  [NUM_CH-1:0] one-hot request to the current channel
//   ch_done     out  [NUM_CH-1:0] sticky alignment success
//   ch_fail     out  [NUM_CH-1:0] sticky alignment timeout
//   busy        out  FSM not idle
//   sweep_done  out  one-cycle end-of-sweep pulse
module roic_deser_align_ctrl #(
    parameter int NUM_CH      = 12,
    parameter int RST_CYC     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_100mhz,
    input  logic              rst_n_eim,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        tap_init,
    input  logic [NUM_CH-1:0] align_ack,
    output logic              deser_reset,
    output logic              dly_tap_ld,
    output logic [4:0]        dly_tap_in,
    output logic [NUM_CH-1:0] align_req,
    output logic [NUM_CH-1:0] ch_done,
    output logic [NUM_CH-1:0] ch_fail,
    output logic              busy,
    output logic              sweep_done
);

    localparam int CNT_MAX = ((RST_CYC > TIMEOUT_CYC) ? RST_CYC : TIMEOUT_CYC) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE, RESET, TAP_LOAD, ALIGN, NEXT, FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        tap_q, tap_d;
    logic              deser_reset_q, deser_reset_d;
    logic              dly_tap_ld_q, dly_tap_ld_d;
    logic [4:0]        dly_tap_in_q, dly_tap_in_d;
    logic [NUM_CH-1:0] align_req_q, align_req_d;
    logic [NUM_CH-1:0] ch_done_q, ch_done_d;
    logic [NUM_CH-1:0] ch_fail_q, ch_fail_d;
    logic              busy_q, busy_d;
    logic              sweep_done_q, sweep_done_d;

    logic [NUM_CH-1:0] ch_sel;
    logic [CH_W-1:0]   ch_nxt;
    logic              ack_sel;

`ifdef ROIC_ALIGN_RETRY_EN
    logic              retry_q, retry_d;
    logic [4:0]        tap_inc;
    assign tap_inc = (tap_q == 5'd31) ? 5'd31 : tap_q + 5'd1;
`endif

    // Mask-based selection keeps the per-channel logic free of variable indexing.
    assign ch_sel  = NUM_CH'(1) << ch_q;
    assign ch_nxt  = ch_q + CH_W'(1);
    assign ack_sel = |(align_ack & ch_sel);

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        cnt_d         = cnt_q;
        tap_d         = tap_q;
        ch_done_d     = ch_done_q;
        ch_fail_d     = ch_fail_q;
        deser_reset_d = 1'b0;
        dly_tap_ld_d  = 1'b0;
        dly_tap_in_d  = 5'd0;
        align_req_d   = '0;
        sweep_done_d  = 1'b0;
`ifdef ROIC_ALIGN_RETRY_EN
        retry_d       = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    ch_done_d     = '0;
                    ch_fail_d     = '0;
                    tap_d         = tap_init;
                    ch_d          = '0;
                    cnt_d         = '0;
                    deser_reset_d = 1'b1;
                    state_d       = RESET;
`ifdef ROIC_ALIGN_RETRY_EN
                    retry_d       = 1'b0;
`endif
                end
            end
            RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d        = '0;
                    dly_tap_ld_d = 1'b1;
                    dly_tap_in_d = tap_q;
                    state_d      = TAP_LOAD;
                end else begin
                    cnt_d         = cnt_q + 1'b1;
                    deser_reset_d = 1'b1;
                end
            end
            TAP_LOAD: begin
                cnt_d       = '0;
                align_req_d = ch_sel;
                state_d     = ALIGN;
            end
            ALIGN: begin
                // Ack is checked first so a coincident ack wins over timeout.
                if (ack_sel) begin
                    ch_done_d = ch_done_q | ch_sel;
                    state_d   = NEXT;
                end else if (cnt_q == TO_LAST) begin
`ifdef ROIC_ALIGN_RETRY_EN
                    if (!retry_q) begin
                        retry_d      = 1'b1;
                        tap_d        = tap_inc;
                        dly_tap_ld_d = 1'b1;
                        dly_tap_in_d = tap_inc;
                        state_d      = TAP_LOAD;
                    end else begin
                        ch_fail_d = ch_fail_q | ch_sel;
                        state_d   = NEXT;
                    end
`else
                    ch_fail_d = ch_fail_q | ch_sel;
                    state_d   = NEXT;
`endif
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    align_req_d = align_req_q;
                end
            end
            NEXT: begin
`ifdef ROIC_ALIGN_RETRY_EN
                retry_d = 1'b0;
`endif
                if (ch_q == CH_LAST) begin
                    sweep_done_d = 1'b1;
                    state_d      = FINISH;
                end else begin
                    ch_d        = ch_nxt;
                    cnt_d       = '0;
                    align_req_d = NUM_CH'(1) << ch_nxt;
                    state_d     = ALIGN;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops every strobe but leaves the status words as they stand.
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            ch_done_d     = ch_done_q;
            ch_fail_d     = ch_fail_q;
            deser_reset_d = 1'b0;
            dly_tap_ld_d  = 1'b0;
            dly_tap_in_d  = 5'd0;
            align_req_d   = '0;
            sweep_done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n_eim) begin
        if (!rst_n_eim) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            cnt_q         <= '0;
            tap_q         <= 5'd0;
            deser_reset_q <= 1'b0;
            dly_tap_ld_q  <= 1'b0;
            dly_tap_in_q  <= 5'd0;
            align_req_q   <= '0;
            ch_done_q     <= '0;
            ch_fail_q     <= '0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
`ifdef ROIC_ALIGN_RETRY_EN
            retry_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            tap_q         <= tap_d;
            deser_reset_q <= deser_reset_d;
            dly_tap_ld_q  <= dly_tap_ld_d;
            dly_tap_in_q  <= dly_tap_in_d;
            align_req_q   <= align_req_d;
            ch_done_q     <= ch_done_d;
            ch_fail_q     <= ch_fail_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
`ifdef ROIC_ALIGN_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    assign deser_reset = deser_reset_q;
    assign dly_tap_ld  = dly_tap_ld_q;
    assign dly_tap_in  = dly_tap_in_q;
    assign align_req   = align_req_q;
    assign ch_done     = ch_done_q;
    assign ch_fail     = ch_fail_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_roic_deser_align_ctrl.sv
// tb/tb_roic_deser_align_ctrl.sv - self-checking bench for roic_deser_align_ctrl
module tb_roic_deser_align_ctrl;

    localparam int NCH   = 12;
    localparam int RST   = 16;
    localparam int TO    = 64;
    localparam int NEVER = 1000;
`ifdef ROIC_ALIGN_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [4:0]     tap_init = 5'd0;
    logic [NCH-1:0] align_ack = '0;
    logic           deser_reset, dly_tap_ld, busy, sweep_done;
    logic [4:0]     dly_tap_in;
    logic [NCH-1:0] align_req, ch_done, ch_fail;

    roic_deser_align_ctrl #(.NUM_CH(NCH), .RST_CYC(RST), .TIMEOUT_CYC(TO)) dut (
        .clk_100mhz(clk), .rst_n_eim(rst_n), .start(start), .abort(abort),
        .tap_init(tap_init), .align_ack(align_ack), .deser_reset(deser_reset),
        .dly_tap_ld(dly_tap_ld), .dly_tap_in(dly_tap_in), .align_req(align_req),
        .ch_done(ch_done), .ch_fail(ch_fail), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Ack delay per channel and attempt, counted in cycles from the first req cycle.
    int dly [NCH][2];
    bit noise_en = 1'b0;
    int last_ch = -1, cur_ch = 0, attempt = 0, age = 0;
    logic [NCH-1:0] prev_req = '0, ack_v;

    int m_rst, m_ld, m_done, m_busy, m_oh;
    logic [4:0] m_ldv[$];

    logic [NCH-1:0] e_done, e_fail;
    int e_busy;
    logic [4:0] e_ldv[$];

    // Channel responder: acks the selected channel after its programmed delay.
    always @(negedge clk) begin
        ack_v = '0;
        if (align_req != '0) begin
            if (align_req != prev_req) begin
                for (int i = 0; i < NCH; i++) if (align_req[i]) cur_ch = i;
                attempt = (cur_ch == last_ch) ? 1 : 0;
                last_ch = cur_ch;
                age = 0;
            end else begin
                age++;
            end
            if (age == dly[cur_ch][attempt]) ack_v = align_req;
        end
        prev_req = align_req;
        if (noise_en) ack_v = ack_v | (NCH'($urandom) & ~align_req);
        align_ack = ack_v;
    end

    always @(negedge clk) begin
        if (deser_reset) m_rst++;
        if (dly_tap_ld) begin m_ld++; m_ldv.push_back(dly_tap_in); end
        if (sweep_done) m_done++;
        if (busy) m_busy++;
        if (align_req != '0 && !$onehot(align_req)) m_oh++;
    end

    // Reference: a sweep is a sequence of attempts per channel; each attempt lasts
    // d+1 cycles if acked at delay d < TO, else TO cycles; NEXT adds one cycle.
    task automatic compute_expected(input int tap);
        int t;
        t = tap;
        e_done = '0; e_fail = '0;
        e_ldv.delete(); e_ldv.push_back(5'(t));
        e_busy = RST + 1 + 1;
        for (int c = 0; c < NCH; c++) begin
            if (dly[c][0] < TO) begin
                e_done[c] = 1'b1; e_busy += dly[c][0] + 2;
            end else if (RETRY) begin
                t = (t < 31) ? t + 1 : 31;
                e_ldv.push_back(5'(t));
                e_busy += TO + 1;
                if (dly[c][1] < TO) begin e_done[c] = 1'b1; e_busy += dly[c][1] + 2; end
                else begin e_fail[c] = 1'b1; e_busy += TO + 1; end
            end else begin
                e_fail[c] = 1'b1; e_busy += TO + 1;
            end
        end
    endtask

    task automatic clear_mon();
        m_rst = 0; m_ld = 0; m_done = 0; m_busy = 0; m_oh = 0; m_ldv.delete();
    endtask

    task automatic set_dly(input int d);
        for (int c = 0; c < NCH; c++) begin dly[c][0] = d; dly[c][1] = d; end
    endtask

    // Drives one sweep and waits for it to end; poke re-pulses start mid-sweep.
    task automatic run_sweep(input int tap, input bit poke, output bit tmo);
        @(negedge clk);
        last_ch = -1;
        clear_mon();
        compute_expected(tap);
        tap_init = 5'(tap); start = 1'b1;
        @(negedge clk);
        start = 1'b0; tap_init = 5'($urandom);
        tmo = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (!busy) begin tmo = 1'b0; break; end
            @(negedge clk);
            start = (poke && i == 30);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({deser_reset, dly_tap_ld, dly_tap_in, align_req, ch_done, ch_fail, busy, sweep_done} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got dr=%b ld=%b tap=%0d req=%h done=%h fail=%h busy=%b sd=%b expected all 0",
                deser_reset, dly_tap_ld, dly_tap_in, align_req, ch_done, ch_fail, busy, sweep_done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_nominal_and_start_busy();
        bit tmo;
        set_dly(10);
        run_sweep(7, 1'b1, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL nominal_timeout: sweep did not finish"); end
        n_vec++; if (m_rst != RST) begin n_err++; $display("FAIL nominal_rst_len: got %0d expected %0d", m_rst, RST); end
        n_vec++; if (m_ld != 1) begin n_err++; $display("FAIL nominal_ld_count: got %0d expected 1", m_ld); end
        n_vec++; if (m_ldv.size() < 1 || m_ldv[0] !== 5'd7) begin n_err++; $display("FAIL nominal_ld_value: got %0d expected 7", (m_ldv.size() > 0) ? m_ldv[0] : 5'd0); end
        n_vec++; if (ch_done !== 12'hFFF) begin n_err++; $display("FAIL nominal_done: got %h expected fff", ch_done); end
        n_vec++; if (ch_fail !== 12'h000) begin n_err++; $display("FAIL nominal_fail: got %h expected 000", ch_fail); end
        n_vec++; if (m_done != 1) begin n_err++; $display("FAIL nominal_sweep_done: got %0d pulses expected 1", m_done); end
        n_vec++; if (m_busy != e_busy) begin n_err++; $display("FAIL nominal_busy_len: got %0d expected %0d", m_busy, e_busy); end
        n_vec++; if (m_oh != 0) begin n_err++; $display("FAIL nominal_onehot: got %0d bad cycles expected 0", m_oh); end
    endtask

    task automatic test_ch5_timeout();
        bit tmo;
        set_dly(10);
        dly[5][0] = NEVER;
        run_sweep(7, 1'b0, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL ch5_timeout: sweep did not finish"); end
        n_vec++; if (ch_done !== e_done) begin n_err++; $display("FAIL ch5_done: got %h expected %h", ch_done, e_done); end
        n_vec++; if (ch_fail !== e_fail) begin n_err++; $display("FAIL ch5_fail: got %h expected %h", ch_fail, e_fail); end
        n_vec++; if (m_ld != e_ldv.size()) begin n_err++; $display("FAIL ch5_ld_count: got %0d expected %0d", m_ld, e_ldv.size()); end
        for (int i = 0; i < e_ldv.size() && i < m_ldv.size(); i++) begin
            n_vec++; if (m_ldv[i] !== e_ldv[i]) begin n_err++; $display("FAIL ch5_ld_value%0d: got %0d expected %0d", i, m_ldv[i], e_ldv[i]); end
        end
        n_vec++; if (m_busy != e_busy) begin n_err++; $display("FAIL ch5_busy_len: got %0d expected %0d", m_busy, e_busy); end
        n_vec++; if (m_done != 1) begin n_err++; $display("FAIL ch5_sweep_done: got %0d expected 1", m_done); end
    endtask

    task automatic test_coincident();
        bit tmo;
        set_dly(10);
        dly[0][0] = TO - 1;
        run_sweep(3, 1'b0, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL coinc_timeout: sweep did not finish"); end
        n_vec++; if (ch_done[0] !== 1'b1) begin n_err++; $display("FAIL coinc_done0: got %b expected 1", ch_done[0]); end
        n_vec++; if (ch_fail[0] !== 1'b0) begin n_err++; $display("FAIL coinc_fail0: got %b expected 0", ch_fail[0]); end
        n_vec++; if (m_busy != e_busy) begin n_err++; $display("FAIL coinc_busy_len: got %0d expected %0d", m_busy, e_busy); end
    endtask

    task automatic test_random();
        bit tmo;
        int tap;
        noise_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < 2; k++)
                    dly[c][k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 4)) : int'($urandom_range(0, 30));
            tap = (s == 0) ? 31 : int'($urandom_range(0, 31));
            run_sweep(tap, 1'b0, tmo);
            n_vec++; if (tmo) begin n_err++; $display("FAIL rand%0d_timeout: sweep did not finish", s); end
            n_vec++; if (ch_done !== e_done) begin n_err++; $display("FAIL rand%0d_done: got %h expected %h", s, ch_done, e_done); end
            n_vec++; if (ch_fail !== e_fail) begin n_err++; $display("FAIL rand%0d_fail: got %h expected %h", s, ch_fail, e_fail); end
            n_vec++; if (m_busy != e_busy) begin n_err++; $display("FAIL rand%0d_busy_len: got %0d expected %0d", s, m_busy, e_busy); end
            n_vec++; if (m_ld != e_ldv.size()) begin n_err++; $display("FAIL rand%0d_ld_count: got %0d expected %0d", s, m_ld, e_ldv.size()); end
            for (int i = 0; i < e_ldv.size() && i < m_ldv.size(); i++) begin
                n_vec++; if (m_ldv[i] !== e_ldv[i]) begin n_err++; $display("FAIL rand%0d_ld_value%0d: got %0d expected %0d", s, i, m_ldv[i], e_ldv[i]); end
            end
            n_vec++; if (m_rst != RST || m_done != 1) begin n_err++; $display("FAIL rand%0d_pulses: got rst=%0d sd=%0d expected %0d and 1", s, m_rst, m_done, RST); end
        end
        noise_en = 1'b0;
    endtask

    task automatic test_abort();
        bit found;
        set_dly(10);
        @(negedge clk);
        last_ch = -1; clear_mon();
        tap_init = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (align_req === 12'h008) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL abort_reach_ch3: align_req never reached 008"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_vec++; if (align_req !== '0) begin n_err++; $display("FAIL abort_req: got %h expected 000", align_req); end
        n_vec++; if (ch_done !== 12'h007) begin n_err++; $display("FAIL abort_done: got %h expected 007", ch_done); end
        repeat (4) @(negedge clk);
        n_vec++; if (m_done != 0) begin n_err++; $display("FAIL abort_sweep_done: got %0d pulses expected 0", m_done); end
        // Abort must beat start when both arrive in IDLE.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_vec++; if (busy !== 1'b0 || deser_reset !== 1'b0) begin n_err++; $display("FAIL abort_start_idle: got busy=%b dr=%b expected 0 0", busy, deser_reset); end
        n_vec++; if (ch_done !== 12'h007) begin n_err++; $display("FAIL abort_start_status: got %h expected 007", ch_done); end
    endtask

    task automatic test_async_reset();
        bit found;
        @(negedge clk);
        tap_init = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (deser_reset === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL areset_enter: deser_reset never rose"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({deser_reset, dly_tap_ld, dly_tap_in, align_req, ch_done, ch_fail, busy, sweep_done} !== '0) begin
            n_err++; $display("FAIL areset_outputs: got dr=%b busy=%b req=%h expected all 0", deser_reset, busy, align_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (busy !== 1'b0 || deser_reset !== 1'b0) begin n_err++; $display("FAIL areset_idle: got busy=%b dr=%b expected 0 0", busy, deser_reset); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal_and_start_busy();
        test_ch5_timeout();
        test_coincident();
        test_random();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/roic_deser_align_ctrl.md
ROIC_DESER_ALIGN_CTRL -- requirements
Module: roic_deser_align_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 12, number of deserializer channels sequenced.
REQ-002 SHALL have parameter RST_CYC, default 16, deser_reset assertion length in cycles.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, per-channel alignment timeout in cycles.
REQ-004 SHALL have port clk_100mhz  in  1  the single clock; all logic is on this clock.
REQ-005 SHALL have port rst_n_eim  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  single-cycle request to run a full alignment sweep.
REQ-007 SHALL have port abort  in  1  level; terminates a sweep in progress.
REQ-008 SHALL have port tap_init  in  5  delay-tap value loaded before alignment.
REQ-009 SHALL have port align_ack  in  NUM_CH  per-channel alignment-complete strobe from the deserializers.
REQ-010 SHALL have port deser_reset  out  1  deserializer reset.
REQ-011 SHALL have port dly_tap_ld  out  1  delay-tap load strobe.
REQ-012 SHALL have port dly_tap_in  out  5  tap value to load.
REQ-013 SHALL have port align_req  out  NUM_CH  one-hot alignment request to the selected channel.
REQ-014 SHALL have port ch_done  out  NUM_CH  sticky per-channel alignment-success status.
REQ-015 SHALL have port ch_fail  out  NUM_CH  sticky per-channel timeout status.
REQ-016 SHALL have port busy  out  1  high whenever the FSM is not IDLE.
REQ-017 SHALL have port sweep_done  out  1  one-cycle pulse at the end of a sweep.

Function
REQ-018 SHALL implement FSM states IDLE, RESET, TAP_LOAD, ALIGN, NEXT and FINISH.
REQ-019 SHALL, in IDLE with start=1 and abort=0, clear ch_done/ch_fail, latch tap_init, set ch=0 and enter RESET.
REQ-020 SHALL assert deser_reset on the cycle after start is accepted.
REQ-021 SHALL hold deser_reset high for exactly RST_CYC cycles in RESET, then enter TAP_LOAD.
REQ-022 SHALL, in TAP_LOAD, assert dly_tap_ld for exactly 1 cycle with dly_tap_in = latched tap, then enter ALIGN.
REQ-023 SHALL, in ALIGN, drive align_req = (1<<ch) and count cycles from 0.
REQ-024 SHALL, in ALIGN with align_ack[ch]=1, set ch_done[ch] and enter NEXT.
REQ-025 SHALL, in ALIGN when the counter reaches TIMEOUT_CYC-1 without ack, set ch_fail[ch] and enter NEXT.
REQ-026 SHALL give ack priority over timeout when both occur in the same cycle: ch_done set, ch_fail not set.
REQ-027 SHALL ignore align_ack bits of non-selected channels and ignore all align_ack outside ALIGN.
REQ-028 SHALL drive align_req to 0 in NEXT; in NEXT, if ch=NUM_CH-1 go to FINISH, else ch=ch+1 and go to ALIGN (no wrap).
REQ-029 SHALL pulse sweep_done for 1 cycle in FINISH, then return to IDLE.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next cycle: all strobes/requests low, status retained, no sweep_done.
REQ-032 SHALL make abort win over start when both are asserted in IDLE, leaving the FSM in IDLE.
REQ-033 SHALL size the cycle counter to hold max(RST_CYC, TIMEOUT_CYC)-1 without overflow.

Reset
REQ-034 SHALL, on rst_n_eim=0 at any time (including mid-sweep), force IDLE, ch=0, counter=0 and latched tap=0.
REQ-035 SHALL, on rst_n_eim=0, force all outputs (deser_reset, dly_tap_ld, dly_tap_in, align_req, ch_done, ch_fail, busy, sweep_done) to 0.

Configuration
REQ-036 SHALL, with macro ROIC_ALIGN_RETRY_EN defined, retry a timed-out channel once (TAP_LOAD with tap+1, saturating at 31, then ALIGN); ch_fail is set only if the retry also times out.
REQ-037 SHALL, without ROIC_ALIGN_RETRY_EN, make a single attempt per channel, with no retry logic present.

Verification (NUM_CH=12, RST_CYC=16, TIMEOUT_CYC=64)
REQ-038 SHALL cover: start with tap_init=7 and each ack 10 cycles after its req -> deser_reset high 16 cycles, one dly_tap_ld with value 7, ch_done=0xFFF, ch_fail=0, one sweep_done.
REQ-039 SHALL cover: ack for ch 5 withheld, macro undefined -> ch_fail=0x020 after 64 cycles, ch_done=0xFDF, sweep completes.
REQ-040 SHALL cover: same stimulus with macro defined and ack on retry -> second tap load with value 8, ch_done=0xFFF, ch_fail=0.
REQ-041 SHALL cover: ack and timeout coincident on cycle 63 for ch 0 -> ch_done[0]=1, ch_fail[0]=0.
REQ-042 SHALL cover: abort during ch 3 ALIGN -> IDLE next cycle, align_req=0, ch_done=0x007, no sweep_done; start during busy -> ignored.
REQ-043 SHALL cover: rst_n_eim low during RESET state -> deser_reset and all outputs 0 immediately (asynchronously); FSM in IDLE after release.
